// File: rtl/ram_sdp.sv
// ram_sdp: simple dual-port RAM with byte-lane writes, selectable read-during-write and a clear engine.
// Define RAM_SDP_OUT_REG_EN to add a second read output register (read latency 2).
module ram_sdp #(
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned NB    = DATA_WIDTH / 8;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
    logic                    vld1_q, vld1_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;
    logic [NB-1:0]           mem_be_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;
    logic [DATA_WIDTH-1:0]   rd_merged_c;

    // Read word, optionally merged with same-cycle write lanes (write-first)
    always_comb begin
        rd_word_c   = mem[rd_addr];
        rd_merged_c = rd_word_c;
        if (RDW_MODE == 1 && wr_en && (rd_addr == wr_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_merged_c[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // Next-state and memory-port selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd1_d       = rd1_q;
        vld1_d      = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = wr_addr;
        mem_wdata_c = wr_data;
        mem_be_c    = wr_be;
        case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = cnt_q;
                mem_wdata_c = INIT_VALUE;
                mem_be_c    = '1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    mem_we_c = wr_en;
                    if (rd_en) begin
                        rd1_d  = rd_merged_c;
                        vld1_d = 1'b1;
                    end
                end
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rd1_q   <= '0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd1_q   <= rd1_d;
            vld1_q  <= vld1_d;
        end
    end

    // Storage is never reset; only the clear engine initialises it
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_addr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
                end
            end
        end
    end

    assign busy = busy_q;

`ifdef RAM_SDP_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  vld2_q, vld2_d;

    // Second stage advances regardless of state so a clear cannot cancel it
    always_comb begin
        rd2_d  = vld1_q ? rd1_q : rd2_q;
        vld2_d = vld1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd2_q  <= '0;
            vld2_q <= 1'b0;
        end else begin
            rd2_q  <= rd2_d;
            vld2_q <= vld2_d;
        end
    end

    assign rd_data  = rd2_q;
    assign rd_valid = vld2_q;
`else
    assign rd_data  = rd1_q;
    assign rd_valid = vld1_q;
`endif

endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp: scoreboard bench driving an old-data and a write-first ram_sdp (16-bit, depth 16) in parallel.
module tb_ram_sdp;
`ifdef RAM_SDP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct { int due; logic [15:0] e; } sb_t;
    typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } chk_t;

    logic        clk = 1'b0;
    logic        rst_n, clr, wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        busy0, busy1, rv0, rv1;
    logic [15:0] rd0, rd1;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    sb_t  q0[$];
    sb_t  q1[$];
    chk_t chkq[$];
    chk_t mc;
    sb_t  ms;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(0), .INIT_VALUE(16'h0000)) u_old (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rv0));

    ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(1), .INIT_VALUE(16'h0000)) u_new (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1));

    // Monitor: drains posted checks and matches read responses against the scoreboard
    always @(negedge clk) begin
        while (chkq.size() > 0) begin
            mc = chkq.pop_front();
            total++;
            if (mc.act !== mc.exp) begin
                bad++;
                $display("FAIL %s actual=%0h required=%0h", mc.nm, mc.act, mc.exp);
            end
        end
        if (rv0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL rd_old unexpected rd_valid actual=1 required=0 cyc=%0d", cyc);
            end else begin
                ms = q0.pop_front();
                if (rd0 !== ms.e || cyc != ms.due) begin
                    bad++;
                    $display("FAIL rd_old actual=%h@%0d required=%h@%0d", rd0, cyc, ms.e, ms.due);
                end
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            total++; bad++;
            ms = q0.pop_front();
            $display("FAIL rd_old missing rd_valid actual=0 required=1 data=%h cyc=%0d", ms.e, cyc);
        end
        if (rv1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL rd_new unexpected rd_valid actual=1 required=0 cyc=%0d", cyc);
            end else begin
                ms = q1.pop_front();
                if (rd1 !== ms.e || cyc != ms.due) begin
                    bad++;
                    $display("FAIL rd_new actual=%h@%0d required=%h@%0d", rd1, cyc, ms.e, ms.due);
                end
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            total++; bad++;
            ms = q1.pop_front();
            $display("FAIL rd_new missing rd_valid actual=0 required=1 data=%h cyc=%0d", ms.e, cyc);
        end
    end

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.nm = nm; c.act = act; c.exp = exp;
        chkq.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] be,
                      input logic re, input logic [3:0] ra, input logic [15:0] e0, input logic [15:0] e1,
                      input logic c);
        sb_t s;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clr = c;
        if (re && !c) begin
            s.due = cyc + LAT;
            s.e = e0; q0.push_back(s);
            s.e = e1; q1.push_back(s);
        end
        step();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_be = 2'b00;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        op(1'b1, a, d, be, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a, e, e, 1'b0);
    endtask

    // Count edges while busy, with reads (and optionally writes to addr 0) held high as noise
    task automatic wait_busy(input string nm, input logic hold_wr);
        int n = 0;
        rd_en = 1'b1; rd_addr = 4'd0;
        if (hold_wr) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h9999; wr_be = 2'b11;
        end
        while (busy0 && n < 40) begin
            step();
            n++;
            if (n == 15) begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0; wr_be = 2'b00;
        post(nm, 32'(n), 32'd16);
        post({nm, "_busy_new"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        step(); step();
        #2;
        post("rst_busy", 32'(busy0), 32'd1);
        post("rst_valid", 32'(rv0 | rv1), 32'd0);
        post("rst_data_old", 32'(rd0), 32'd0);
        post("rst_data_new", 32'(rd1), 32'd0);
        step();
        rst_n = 1'b1;
        wait_busy("init_len", 1'b0);

        for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000);

        // Byte lanes and zero byte-enable
        wr(4'd3, 16'hBEEF, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        rd(4'd3, 16'hBE34);
        wr(4'd4, 16'hFFFF, 2'b00);
        rd(4'd4, 16'h0000);

        // Read-during-write, full and partial lanes, then a different-address read
        wr(4'd5, 16'h0011, 2'b11);
        op(1'b1, 4'd5, 16'h0022, 2'b11, 1'b1, 4'd5, 16'h0011, 16'h0022, 1'b0);
        op(1'b1, 4'd5, 16'hAB33, 2'b01, 1'b1, 4'd5, 16'h0022, 16'h0033, 1'b0);
        rd(4'd5, 16'h0033);
        op(1'b1, 4'd6, 16'h7777, 2'b11, 1'b1, 4'd5, 16'h0033, 16'h0033, 1'b0);
        rd(4'd6, 16'h7777);

        // Clear request drops the same-cycle write and read
        wr(4'd7, 16'h00AA, 2'b11);
        op(1'b1, 4'd8, 16'h0055, 2'b11, 1'b1, 4'd7, 16'h0, 16'h0, 1'b1);
        wait_busy("clr_len", 1'b1);
        rd(4'd7, 16'h0000);
        rd(4'd8, 16'h0000);
        rd(4'd0, 16'h0000);

        // Reset mid-clear at cnt=9
        wr(4'd6, 16'h7777, 2'b11);
        rd(4'd6, 16'h7777);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        repeat (9) step();
        #2;
        rst_n = 1'b0;
        #1;
        post("midrst_busy_old", 32'(busy0), 32'd1);
        post("midrst_busy_new", 32'(busy1), 32'd1);
        post("midrst_valid", 32'(rv0 | rv1), 32'd0);
        post("midrst_data_old", 32'(rd0), 32'd0);
        post("midrst_data_new", 32'(rd1), 32'd0);
        step();
        rst_n = 1'b1;
        wait_busy("restart_len", 1'b0);
        rd(4'd6, 16'h0000);

        // Back-to-back reads
        for (int a = 0; a < 4; a++) wr(4'(a), 16'h00A0 + 16'(a), 2'b11);
        for (int a = 0; a < 4; a++) rd(4'(a), 16'h00A0 + 16'(a));

        // A read in flight survives a following clear
        rd(4'd1, 16'h00A1);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        wait_busy("clr2_len", 1'b0);
        rd(4'd1, 16'h0000);

        repeat (4) step();
        post("sb_left_old", 32'(q0.size()), 32'd0);
        post("sb_left_new", 32'(q1.size()), 32'd0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
